// File: rtl/lsu_pkg.sv
// LSU shared types: funct3 codes, FSM states, legality check.
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned H/W accesses illegal.
package lsu_pkg;

  localparam int OFF_W = 2;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic logic illegal(
    input logic             we,
    input logic [2:0]       f3,
    input logic [OFF_W-1:0] off
  );
    logic bad;
    logic mis;
    bad = 1'b1;
    mis = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    if (f3 == F3_H || f3 == F3_HU)
      mis = off[0];
    else if (f3 == F3_W)
      mis = |off;
    return bad | (TRAP_EN & mis);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// LSU lane steering: store byte enables/replication, load extract/extend.
// Low offset bits are cleared per access size so misaligned accesses degrade.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic             we,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic [3:0]       be,
  output logic [31:0]      mem_wdata,
  output logic [31:0]      ld_data
);

  logic [31:0] wd;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        sgn;

  always_comb begin
    be        = '0;
    wd        = '0;
    ld_data   = '0;
    bsel      = rdata[{off, 3'b000} +: 8];
    hsel      = off[1] ? rdata[31:16] : rdata[15:0];
    sgn       = ~funct3[2];
    unique case (1'b1)
      (funct3[1:0] == 2'b00): begin
        be      = 4'b0001 << off;
        wd      = {4{wdata[7:0]}};
        ld_data = {{24{sgn & bsel[7]}}, bsel};
      end
      (funct3[1:0] == 2'b01): begin
        be      = 4'b0011 << {off[1], 1'b0};
        wd      = {2{wdata[15:0]}};
        ld_data = {{16{sgn & hsel[15]}}, hsel};
      end
      default: begin
        be      = 4'b1111;
        wd      = wdata;
        ld_data = rdata;
      end
    endcase
    mem_wdata = we ? wd : '0;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access, IDLE/REQ/WAIT/RESP FSM.
// Misalignment trapping selected by LSU_MISALIGN_TRAP_EN (see lsu_pkg).
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t state, nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic              err_q;
  logic              ill_in;
  logic              accept;
  logic [3:0]        be;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] ld;

  assign ill_in = illegal(req_we, req_funct3, req_addr[OFF_W-1:0]);
  assign accept = (state == S_IDLE) && req_valid;

  lsu_align u_align (
    .funct3    (f3_q),
    .off       (addr_q[OFF_W-1:0]),
    .we        (we_q),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be),
    .mem_wdata (wd),
    .ld_data   (ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          nxt = ill_in ? S_RESP : S_REQ;
      end
      S_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready)
          nxt = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid)
          nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        nxt       = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Bus and response outputs are zero outside their owning states.
  assign mem_addr  = mem_valid ?
                     {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_we    = mem_valid & we_q;
  assign mem_be    = mem_valid ? be : '0;
  assign mem_wdata = mem_valid ? wd : '0;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
      we_q    <= req_we;
      err_q   <= ill_in;
      rdata_q <= '0;
    end else if (state == S_WAIT && mem_rvalid) begin
      rdata_q <= ld;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver queues expected bus/response,
// negedge monitor pops and compares.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        err;
    int          acc;
    int          lat;
  } rsp_t;

  bus_t bq[$];
  rsp_t rq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", nm);
  endtask

  // Monitor: bus handshakes, REQ stability, responses.
  logic        pv;
  logic [31:0] pa, pw;
  logic [3:0]  pb;
  initial pv = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (mem_valid && pv) begin
        chk("addr_stable", mem_addr, pa);
        chk("be_stable", {28'd0, mem_be}, {28'd0, pb});
        chk("wd_stable", mem_wdata, pw);
      end
      if (mem_valid && mem_ready) begin
        if (bq.size() == 0) flag("bus_unexpected");
        else begin
          bus_t e;
          e = bq.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          chk("mem_be", {28'd0, mem_be}, {28'd0, e.be});
          chk("mem_wdata", mem_wdata, e.wd);
        end
      end
      pv = mem_valid && !mem_ready;
      pa = mem_addr;
      pb = mem_be;
      pw = mem_wdata;
      if (rsp_valid) begin
        if (rq.size() == 0) flag("rsp_unexpected");
        else begin
          rsp_t r;
          r = rq.pop_front();
          chk({r.nm, "_rdata"}, rsp_rdata, r.rd);
          chk({r.nm, "_err"}, {31'd0, rsp_err}, {31'd0, r.err});
          chk({r.nm, "_lat"}, cyc - r.acc + 1, r.lat);
        end
      end
    end
  end

  // Issue one access starting at a negedge; mem_ready withheld dly cycles.
  task automatic access(
    input string       nm,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input logic [31:0] e_addr,
    input logic [3:0]  e_be,
    input logic [31:0] e_wd,
    input logic [31:0] e_rd,
    input logic        e_err,
    input int          dly,
    input bit          pulse
  );
    rsp_t r;
    int   t;
    if (!e_err) bq.push_back('{e_addr, we, e_be, e_wd});
    r.nm  = nm;
    r.rd  = e_rd;
    r.err = e_err;
    r.acc = cyc + 1;
    r.lat = e_err ? 1 : (we ? 2 + dly : 3 + dly);
    rq.push_back(r);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    mem_ready  = (dly == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = pulse;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk({nm, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
      if (pulse) req_valid = ~req_valid;
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    if (!we && !e_err) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) flag({nm, "_timeout"});
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_we     = 1'b0;
    req_funct3 = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #3;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access("sw", 1, 3'd2, 32'h100, 32'hDEADBEEF, 0,
           32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0);
    access("lb", 0, 3'd0, 32'h103, 0, 32'h80FF1234,
           32'h100, 4'b1000, 0, 32'hFFFFFF80, 0, 0, 0);
    access("lbu", 0, 3'd4, 32'h103, 0, 32'h80FF1234,
           32'h100, 4'b1000, 0, 32'h00000080, 0, 0, 0);
    access("sh", 1, 3'd1, 32'h102, 32'h0000ABCD, 0,
           32'h100, 4'b1100, 32'hABCDABCD, 0, 0, 0, 0);
    access("sb", 1, 3'd0, 32'h101, 32'h123456A5, 0,
           32'h100, 4'b0010, 32'hA5A5A5A5, 0, 0, 0, 0);
    access("lb_pos", 0, 3'd0, 32'h201, 0, 32'h00007F00,
           32'h200, 4'b0010, 0, 32'h0000007F, 0, 0, 0);
    access("lh_hi", 0, 3'd1, 32'h102, 0, 32'h80011234,
           32'h100, 4'b1100, 0, 32'hFFFF8001, 0, 0, 0);
    access("lhu", 0, 3'd5, 32'h100, 0, 32'h8001F234,
           32'h100, 4'b0011, 0, 32'h0000F234, 0, 0, 0);
    access("lw", 0, 3'd2, 32'h300, 0, 32'h12345678,
           32'h300, 4'b1111, 0, 32'h12345678, 0, 0, 0);
    access("ill_st3", 1, 3'd3, 32'h100, 32'h1, 0,
           0, 0, 0, 0, 1, 0, 0);
    access("ill_ld6", 0, 3'd6, 32'h100, 0, 0,
           0, 0, 0, 0, 1, 0, 0);
    access("ill_sbu", 1, 3'd4, 32'h100, 32'h1, 0,
           0, 0, 0, 0, 1, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    access("lw_mis", 0, 3'd2, 32'h101, 0, 32'h12345678,
           0, 0, 0, 0, 1, 0, 0);
    access("lh_mis", 0, 3'd1, 32'h101, 0, 32'hAAAA8765,
           0, 0, 0, 0, 1, 0, 0);
`else
    access("lw_mis", 0, 3'd2, 32'h101, 0, 32'h12345678,
           32'h100, 4'b1111, 0, 32'h12345678, 0, 0, 0);
    access("lh_mis", 0, 3'd1, 32'h101, 0, 32'hAAAA8765,
           32'h100, 4'b0011, 0, 32'hFFFF8765, 0, 0, 0);
`endif
    access("sw_stall", 1, 3'd2, 32'h104, 32'h11223344, 0,
           32'h104, 4'b1111, 32'h11223344, 0, 0, 5, 1);
    access("lh_stall", 0, 3'd1, 32'h106, 0, 32'hC0DE0000,
           32'h104, 4'b1100, 0, 32'hFFFFC0DE, 0, 2, 0);

    // Reset while waiting for read data; a stray rvalid must be ignored.
    bq.push_back('{32'h200, 1'b0, 4'b1111, 32'h0});
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h200;
    mem_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("wrst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("wrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wrst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wrst_req_ready", {31'd0, req_ready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrst_idle", {31'd0, req_ready}, 32'd1);

    chk("bus_q_empty", bq.size(), 32'd0);
    chk("rsp_q_empty", rq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have req_valid  input  1  execute stage presents an access.
REQ-006 SHALL have req_ready  output  1  the LSU accepts an access; high only in IDLE.
REQ-007 SHALL have req_addr  input  ADDR_W  effective address taken from the ALU result.
REQ-008 SHALL have req_wdata  input  32  store data, the rs2 value.
REQ-009 SHALL have req_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have req_funct3  input  3  access size and signedness:
  - loads: LB=0, LH=1, LW=2, LBU=4, LHU=5;
  - stores: SB=0, SH=1, SW=2.
REQ-011 SHALL have mem_valid  output  1, mem_ready  input  1  bus request handshake.
REQ-012 SHALL have mem_addr  output  ADDR_W  word-aligned address, with bits [1:0] = 0.
REQ-013 SHALL have mem_we  output  1, mem_be  output  4, mem_wdata  output  32  write controls.
REQ-014 SHALL have mem_rvalid  input  1, mem_rdata  input  32  read return.
REQ-015 SHALL have rsp_valid  output  1, rsp_rdata  output  32, rsp_err  output  1  writeback response.

Function
REQ-016 SHALL implement the state machine IDLE, REQ, WAIT, RESP.
REQ-017 SHALL accept when req_valid and req_ready are both high in IDLE, registering addr, wdata, we and funct3, then go to REQ.
  - If the access is illegal (REQ-024), it SHALL go to RESP instead.
REQ-018 In REQ, SHALL hold mem_valid high with mem_addr, mem_we, mem_be and mem_wdata stable until mem_ready is high.
  - On a store handshake: go to RESP.
  - On a load handshake: go to WAIT.
REQ-019 In WAIT, SHALL sample mem_rvalid only.
  - When mem_rvalid is high, capture the formatted read data and go to RESP.
  - mem_rvalid arriving in any other state SHALL be ignored.
REQ-020 In RESP, SHALL drive rsp_valid high for exactly one cycle, then return to IDLE.
  - rsp_rdata and rsp_err SHALL be valid only while rsp_valid is high.
  - rsp_rdata SHALL be 0 for stores and for errors.
REQ-021 Store lane formatting:
  - SB: mem_be = 4'b0001 << addr[1:0]; mem_wdata = byte 0 of wdata replicated ×4.
  - SH: mem_be = 4'b0011 << {addr[1],1'b0}; mem_wdata = halfword 0 of wdata replicated ×2.
  - SW: mem_be = 4'b1111; mem_wdata = wdata.
REQ-022 Load formatting:
  - Extract the addressed byte or halfword from mem_rdata.
  - LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
  - LW SHALL pass mem_rdata through unchanged.
REQ-023 For loads, mem_be SHALL equal the lanes that are read; mem_wdata SHALL be 0.
REQ-024 Any unlisted funct3 value SHALL be illegal: no bus request, and rsp_err = 1.
REQ-025 Minimum latency from accept to rsp_valid:
  - store: 2 cycles;
  - load: 3 cycles;
  - illegal access: 1 cycle.
REQ-026 While not in IDLE, req_valid SHALL be ignored; there is no queueing.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state IDLE, regardless of the current state.
REQ-028 During reset, outputs SHALL be:
  - mem_valid = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0;
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - req_ready = 1.
REQ-029 A reset arriving mid-access SHALL abandon that access; a later mem_rvalid for it SHALL be ignored.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are LH, LHU or SH with addr[0] = 1, and LW or SW with addr[1:0] != 0.
  - A misaligned access SHALL be illegal (REQ-024): no bus request, rsp_err = 1.
REQ-031 Macro LSU_MISALIGN_TRAP_EN undefined:
  - The offending low address bits SHALL be treated as 0 and the access SHALL proceed.
  - rsp_err SHALL flag only illegal funct3 values.

Structure
REQ-032 Package lsu_pkg SHALL hold:
  - the funct3 constants;
  - the state enumeration;
  - the offset-width localparam.
REQ-033 Byte-lane and extension logic SHALL live in the combinational sub-module lsu_align; lsu holds only the FSM and registers.

Verification
REQ-034 SW, addr 0x100, wdata 0xDEADBEEF, mem_ready high in the first REQ cycle:
  - expect mem_addr 0x100, mem_be 1111, mem_wdata 0xDEADBEEF;
  - expect rsp_valid 2 cycles after accept, with rsp_err 0.
REQ-035 LB, addr 0x103, mem_rdata 0x80FF1234 → rsp_rdata 0xFFFFFF80; the same access as LBU → 0x00000080.
REQ-036 SH, addr 0x102, wdata 0x0000ABCD → mem_be 1100, mem_wdata 0xABCDABCD, mem_addr 0x100.
REQ-037 LW, addr 0x101:
  - macro defined: no mem_valid; rsp_valid 1 cycle after accept with rsp_err 1;
  - macro undefined: mem_addr 0x100 and a normal load.
REQ-038 mem_ready held low for 5 cycles while req_valid is pulsed:
  - mem_valid and mem_addr stay stable;
  - req_ready stays 0;
  - only one rsp_valid is produced.
REQ-039 rst_n low while in WAIT:
  - mem_valid and rsp_valid are 0 with no clock edge;
  - after release, req_ready is 1;
  - a stray mem_rvalid produces no rsp_valid.
